sa_sequencer: RTL

SA_SEQUENCER -- requirements
Module: sa_sequencer

---
 rtl/sa_pkg.sv | 27 ++
 rtl/sa_skew_addr_gen.sv | 33 +++
 rtl/sa_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared types and constants for the systolic-array sequencer.
// Holds the FSM state enum, default zero-point address and length limit.
package sa_pkg;

   localparam int ADDR_W_DEF = 10;

   typedef logic [ADDR_W_DEF-1:0] addr_t;

   // Memory word that always reads back as zero; used as filler
   // while the skewed wavefront is ramping up or down.
   localparam addr_t ZERO_POINT_ADDR_DEF = 10'h355;

   localparam int MAX_VEC_LEN = 16;

   typedef enum logic [2:0] {
      IDLE,
      FEED,
      DRAIN,
      READ,
      DONE
   } sa_state_e;

   function automatic logic vec_len_ok(input logic [4:0] k);
      return (k != 5'd0) && (k <= 5'(MAX_VEC_LEN));
   endfunction

endpackage

// File: rtl/sa_skew_addr_gen.sv
// sa_skew_addr_gen: top-operand read address for one systolic column.
// Ports: en (FEED active), t (step), j (column), k (K), base -> addr.
module sa_skew_addr_gen
   import sa_pkg::*;
#(
   parameter int                PE_NUMBER = 3,
   parameter int                ADDR_W    = 10,
   parameter logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_POINT_ADDR_DEF)
) (
   input  logic              en,
   input  logic [4:0]        t,
   input  logic [4:0]        j,
   input  logic [4:0]        k,
   input  logic [ADDR_W-1:0] base,
   output logic [ADDR_W-1:0] addr
);

   logic [4:0]        d;
   logic              hit;
   logic [ADDR_W-1:0] off;

   // Column j lags column 0 by j steps; row index is t-j.
   assign d   = t - j;
   assign hit = en && (t >= j) && (d < k);

   // A starts K words after x, row-major with PE_NUMBER words per row.
   assign off = ADDR_W'(k)
              + ADDR_W'(d) * ADDR_W'(PE_NUMBER)
              + ADDR_W'(j);

   assign addr = hit ? base + off : ZERO_ADDR;

endmodule

// File: rtl/sa_sequencer.sv
// sa_sequencer: job FSM feeding a systolic array and writing results.
// Ports: start/vec_len/src/dst/abort in; read addrs, read, w_*, busy,
// done, err out. Optional perf_cycles when SA_SEQ_PERF_CNT_EN is defined.
module sa_sequencer
   import sa_pkg::*;
#(
   parameter int                PE_NUMBER       = 3,
   parameter int                DATA_W          = 16,
   parameter int                ADDR_W          = 10,
   parameter int                DRAIN_LAT       = 2,
   parameter logic [ADDR_W-1:0] ZERO_POINT_ADDR = ADDR_W'(ZERO_POINT_ADDR_DEF)
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic [4:0]                  vec_len,
   input  logic [ADDR_W-1:0]           src_addr,
   input  logic [ADDR_W-1:0]           dst_addr,
   input  logic                        abort,
   output logic [ADDR_W-1:0]           l_d_o_addr,
   output logic [PE_NUMBER*ADDR_W-1:0] pe_t_o_addr,
   output logic                        read,
   input  logic [DATA_W-1:0]           res_i,
   output logic [ADDR_W-1:0]           w_addr,
   output logic [DATA_W-1:0]           w_data,
   output logic                        w_en,
   output logic                        busy,
   output logic                        done,
`ifdef SA_SEQ_PERF_CNT_EN
   output logic [31:0]                 perf_cycles,
`endif
   output logic                        err
);

   localparam int CNT_W = 8;
   localparam logic [5:0]       PE6        = 6'(PE_NUMBER);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LAT - 1);
   localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(PE_NUMBER - 1);

   sa_state_e         state;
   logic [4:0]        t;
   logic [4:0]        k_q;
   logic [CNT_W-1:0]  cnt;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W-1:0] dst_q;

   logic              in_feed;
   logic [5:0]        feed_last;
   logic              feed_end;

   assign in_feed   = (state == FEED);
   // FEED spans K+PE-1 steps so the last column sees its last row.
   assign feed_last = {1'b0, k_q} + PE6 - 6'd2;
   assign feed_end  = ({1'b0, t} == feed_last);

   assign l_d_o_addr = (in_feed && (t < k_q))
                     ? src_q + ADDR_W'(t)
                     : ZERO_POINT_ADDR;

   for (genvar g = 0; g < PE_NUMBER; g++) begin : g_col
      sa_skew_addr_gen #(
         .PE_NUMBER (PE_NUMBER),
         .ADDR_W    (ADDR_W),
         .ZERO_ADDR (ZERO_POINT_ADDR)
      ) u_col (
         .en   (in_feed),
         .t    (t),
         .j    (5'(g)),
         .k    (k_q),
         .base (src_q),
         .addr (pe_t_o_addr[g*ADDR_W +: ADDR_W])
      );
   end

   // Array output is already aligned with the write strobe.
   assign w_data = res_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         t      <= '0;
         k_q    <= '0;
         cnt    <= '0;
         src_q  <= '0;
         dst_q  <= '0;
         read   <= 1'b0;
         w_en   <= 1'b0;
         w_addr <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         w_en <= 1'b0;
         done <= 1'b0;
         if (abort && (state != IDLE)) begin
            state <= IDLE;
            t     <= '0;
            cnt   <= '0;
            read  <= 1'b0;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start && !abort) begin
                     if (vec_len_ok(vec_len)) begin
                        k_q   <= vec_len;
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        err   <= 1'b0;
                        t     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= FEED;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               FEED: begin
                  if (feed_end) begin
                     t   <= '0;
                     cnt <= '0;
                     if (DRAIN_LAT == 0) begin
                        read  <= 1'b1;
                        state <= READ;
                     end else begin
                        state <= DRAIN;
                     end
                  end else begin
                     t <= t + 5'd1;
                  end
               end
               DRAIN: begin
                  if (cnt == DRAIN_LAST) begin
                     cnt   <= '0;
                     read  <= 1'b1;
                     state <= READ;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               READ: begin
                  // Write-back trails the shift-out by one cycle.
                  w_en   <= 1'b1;
                  w_addr <= dst_q + ADDR_W'(cnt);
                  if (cnt == READ_LAST) begin
                     cnt   <= '0;
                     read  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  read  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

`ifdef SA_SEQ_PERF_CNT_EN
   logic [31:0] busy_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_cnt    <= '0;
         perf_cycles <= '0;
      end else if (abort && (state != IDLE)) begin
         busy_cnt <= '0;
      end else if (state == DONE) begin
         // DONE is itself a busy cycle.
         perf_cycles <= busy_cnt + 32'd1;
         busy_cnt    <= '0;
      end else if (busy) begin
         busy_cnt <= busy_cnt + 32'd1;
      end
   end
`endif

endmodule
